fft_sequencer: RTL

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_sequencer.sv
// fft_sequencer: control sequencer for a direct-form DFT (sample load, N x N MAC sweep, per-bin result handoff).
// Latency: start to done is 1 + N + N*(N+PIPE_LAT+1) + 1 cycles unstalled; acc_ce trails the MAC issue by PIPE_LAT.
// Backpressure: ld_valid gaps stall LOAD without penalty; res_ready low holds OUT with res_valid and k_index frozen.
module fft_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              n_Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] samp_number,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [ADDR_W-1:0] n_index,
    output logic [ADDR_W-1:0] k_index,
    output logic              acc_ce,
    output logic              acc_clr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int FW = $clog2(PIPE_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FLUSH,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_len_q, n_len_d;
    logic [ADDR_W-1:0] last_idx;
    logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] ld_addr_d, n_index_d, k_index_d;
    logic              ld_ready_d, acc_clr_d, res_valid_d, busy_d, done_d, err_d;
    logic              issue_q, issue_d;

    assign last_idx = n_len_q - ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        n_len_d     = n_len_q;
        flush_cnt_d = flush_cnt_q;
        ld_addr_d   = ld_addr;
        n_index_d   = n_index;
        k_index_d   = k_index;
        ld_ready_d  = 1'b0;
        acc_clr_d   = 1'b0;
        res_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = 1'b1;

        if (abort) begin
            state_d     = S_IDLE;
            n_len_d     = '0;
            flush_cnt_d = '0;
            ld_addr_d   = '0;
            n_index_d   = '0;
            k_index_d   = '0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        if (samp_number == '0) begin
                            err_d = 1'b1;
                        end else begin
                            n_len_d    = samp_number;
                            ld_addr_d  = '0;
                            ld_ready_d = 1'b1;
                            busy_d     = 1'b1;
                            state_d    = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    ld_ready_d = 1'b1;
                    if (ld_valid && ld_ready) begin
                        ld_addr_d = ld_addr + ADDR_W'(1);
                        if (ld_addr == last_idx) begin
                            ld_ready_d = 1'b0;
                            n_index_d  = '0;
                            k_index_d  = '0;
                            acc_clr_d  = 1'b1;
                            state_d    = S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    if (n_index == last_idx) begin
                        // n_index holds at N-1 while the product pipeline drains
                        if (PIPE_LAT == 0) begin
                            res_valid_d = 1'b1;
                            state_d     = S_OUT;
                        end else begin
                            flush_cnt_d = '0;
                            state_d     = S_FLUSH;
                        end
                    end else begin
                        n_index_d = n_index + ADDR_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FW'(PIPE_LAT - 1)) begin
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FW'(1);
                    end
                end
                S_OUT: begin
                    res_valid_d = 1'b1;
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        if (k_index == last_idx) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            k_index_d = k_index + ADDR_W'(1);
                            n_index_d = '0;
                            acc_clr_d = 1'b1;
                            state_d   = S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    ld_addr_d = '0;
                    n_index_d = '0;
                    k_index_d = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end

        issue_d = (state_d == S_MAC);
    end

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            state_q     <= S_IDLE;
            n_len_q     <= '0;
            flush_cnt_q <= '0;
            issue_q     <= 1'b0;
            ld_addr     <= '0;
            n_index     <= '0;
            k_index     <= '0;
            ld_ready    <= 1'b0;
            acc_clr     <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_len_q     <= n_len_d;
            flush_cnt_q <= flush_cnt_d;
            issue_q     <= issue_d;
            ld_addr     <= ld_addr_d;
            n_index     <= n_index_d;
            k_index     <= k_index_d;
            ld_ready    <= ld_ready_d;
            acc_clr     <= acc_clr_d;
            res_valid   <= res_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    // acc_ce is the issue flag aligned to the product arriving at the accumulator
    generate
        if (PIPE_LAT == 0) begin : g_no_lat
            assign acc_ce = issue_q;
        end else begin : g_lat
            logic [PIPE_LAT-1:0] ce_pipe;

            always_ff @(posedge clk or negedge n_Reset) begin
                if (!n_Reset) begin
                    ce_pipe <= '0;
                end else if (abort) begin
                    ce_pipe <= '0;
                end else begin
                    ce_pipe[0] <= issue_q;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        ce_pipe[i] <= ce_pipe[i-1];
                    end
                end
            end

            assign acc_ce = ce_pipe[PIPE_LAT-1];
        end
    endgenerate

endmodule
